serial_link_arbiter: RTL



---
 rtl/serial_link_pkg.sv | 26 ++
 rtl/serial_bit_timer.sv | 58 +++++
 rtl/serial_link_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared constants for the two-channel serial link arbiter: FSM encoding,
// frame layout and channel ids.
package serial_link_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t GAP   = 2'd2;

  localparam int FRAME_BITS = 11;

  typedef logic [3:0] bit_idx_t;
  localparam bit_idx_t LAST_BIT = 4'(FRAME_BITS - 1);

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: divides Clk into SCout half-periods of DIV cycles and
// strobes the last cycle of each bit period.
module serial_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic run_i,
  input  logic last_bit_i,
  output logic sc_o,
  output logic bit_start_o,
  output logic bit_end_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sc_q, sc_d;
  logic          half_end;

  assign half_end    = run_i && (div_q == DIV_LAST);
  assign bit_end_o   = half_end && sc_q;
  // A new bit begins on the edge that closes every period except the stop bit.
  assign bit_start_o = bit_end_o && !last_bit_i;
  assign sc_o        = sc_q;

  always_comb begin
    div_d = div_q;
    sc_d  = sc_q;
    if (load_i) begin
      div_d = '0;
      sc_d  = 1'b0;
    end else if (run_i) begin
      if (half_end) begin
        div_d = '0;
        sc_d  = sc_q ? last_bit_i : 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d = '0;
      sc_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      sc_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      sc_q  <= sc_d;
    end
  end

endmodule

// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter sharing one framed serial link between two byte sources.
// state | meaning
// IDLE  | link quiet, arbitrate on any request
// SHIFT | sending start, D7..D0, parity, stop
// GAP   | inter-frame idle, SCout/SDout held high
module serial_link_arbiter
  import serial_link_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int GAP_BITS   = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req1,
  input  logic [7:0] PDin1,
  output logic       Ack1,
  input  logic       Req2,
  input  logic [7:0] PDin2,
  output logic       Ack2,
  output logic       SCout,
  output logic       SDout,
  output logic       Busy,
  output logic       GntId
);

  localparam int GAP_LEN = GAP_BITS * 2 * DIV;
  localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  state_t        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  bit_idx_t      bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          ack1_q, ack1_d;
  logic          ack2_q, ack2_d;
  logic          busy_q, busy_d;
  logic          sd_q, sd_d;

  logic       grant;
  logic       winner;
  logic [7:0] win_data;
  logic       last_bit;
  logic       bit_start;
  logic       bit_end;
  logic       sc;

  assign grant    = (state_q == IDLE) && (Req1 || Req2);
  // On a tie the channel that did not go last wins.
  assign winner   = Req2 ? (Req1 ? ~last_q : CH2) : CH1;
  assign win_data = (winner == CH2) ? PDin2 : PDin1;
  assign last_bit = (bit_cnt_q == LAST_BIT);

  serial_bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .load_i     (grant),
    .run_i      (state_q == SHIFT),
    .last_bit_i (last_bit),
    .sc_o       (sc),
    .bit_start_o(bit_start),
    .bit_end_o  (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    ack1_d    = 1'b0;
    ack2_d    = 1'b0;
    busy_d    = busy_q;
    sd_d      = sd_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = SHIFT;
          sr_d      = win_data;
          par_d     = frame_parity(win_data, PAR_ODD);
          last_d    = winner;
          gnt_d     = winner;
          ack1_d    = (winner == CH1);
          ack2_d    = (winner == CH2);
          busy_d    = 1'b1;
          sd_d      = START_BIT;
          bit_cnt_d = '0;
        end
      end

      SHIFT: begin
        if (bit_end && last_bit) begin
          sd_d = STOP_BIT;
          if (GAP_LEN == 0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end else if (bit_start) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            sd_d = sr_q[7];
            sr_d = {sr_q[6:0], 1'b0};
          end else if (bit_cnt_q == 4'd8) begin
            sd_d = par_q;
          end else begin
            sd_d = STOP_BIT;
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sd_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      last_q    <= CH2;
      gnt_q     <= CH1;
      ack1_q    <= 1'b0;
      ack2_q    <= 1'b0;
      busy_q    <= 1'b0;
      sd_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      ack1_q    <= ack1_d;
      ack2_q    <= ack2_d;
      busy_q    <= busy_d;
      sd_q      <= sd_d;
    end
  end

  assign Ack1  = ack1_q;
  assign Ack2  = ack2_q;
  assign SCout = sc;
  assign SDout = sd_q;
  assign Busy  = busy_q;
  assign GntId = gnt_q;

endmodule
